// File: rtl/poly_alu_controller_if.sv
// poly_alu_controller_if: note events, envelope parameters and mix outputs of the polyphonic controller.
interface poly_alu_controller_if #(
    parameter int NVOICES = 4,
    parameter int AW      = 6,
    parameter int OW      = AW + 1 + $clog2(NVOICES)
);
    logic               note_on;
    logic               note_off;
    logic [3:0]         note;
    logic [2:0]         octave;
    logic [15:0]        half_period;
    logic [AW-1:0]      amplitude;
    logic [AW-1:0]      attack;
    logic [AW-1:0]      decay;
    logic [AW-1:0]      sustain;
    logic [AW-1:0]      rel;
    logic [OW-1:0]      wave_out;
    logic [NVOICES-1:0] voice_busy;
    logic               drop;
    modport master (
        output note_on, note_off, note, octave, half_period, amplitude, attack, decay, sustain, rel,
        input  wave_out, voice_busy, drop
    );
    modport slave (
        input  note_on, note_off, note, octave, half_period, amplitude, attack, decay, sustain, rel,
        output wave_out, voice_busy, drop
    );
endinterface

// File: rtl/poly_alu_controller.sv
// poly_alu_controller: allocates note events to voices, each with a square oscillator and linear ADSR,
// and registers the signed sum of all voice samples.
module poly_alu_controller #(
    parameter int NVOICES  = 4,
    parameter int AW       = 6,
    parameter int TICK_DIV = 50000,
    parameter int OW       = AW + 1 + $clog2(NVOICES)
) (
    input logic clk,
    input logic reset,
    poly_alu_controller_if.slave bus
);
    localparam int PW = $clog2(TICK_DIV + 1);
    typedef enum logic [2:0] {IDLE, ATTACK, DECAY, SUSTAIN, RELEASE} env_t;
    env_t               state_q [NVOICES], state_d [NVOICES];
    logic [6:0]         key_q   [NVOICES], key_d   [NVOICES];
    logic [15:0]        hp_q    [NVOICES], hp_d    [NVOICES];
    logic [15:0]        cnt_q   [NVOICES], cnt_d   [NVOICES];
    logic [AW-1:0]      peak_q  [NVOICES], peak_d  [NVOICES];
    logic [AW-1:0]      level_q [NVOICES], level_d [NVOICES];
    logic [AW-1:0]      step_q  [NVOICES], step_d  [NVOICES];
    logic               pol_q   [NVOICES], pol_d   [NVOICES];
    logic [PW-1:0]      pre_q, pre_d;
    logic [OW-1:0]      wave_q, wave_d;
    logic               drop_q, drop_d;
    logic [NVOICES-1:0] hit, take, busy;
    logic [6:0]         key_in;
    logic [AW-1:0]      sus, par;
    logic [AW:0]        up;
    logic signed [AW:0] smp;
    logic               tick, go, wrap, dn, hit_any, free_any;
    always_comb begin
        key_in   = {bus.octave, bus.note};
        tick     = pre_q == PW'(TICK_DIV - 1);
        pre_d    = tick ? '0 : pre_q + PW'(1);
        hit      = '0;
        take     = '0;
        busy     = '0;
        hit_any  = 1'b0;
        free_any = 1'b0;
        wave_d   = '0;
        sus      = '0;
        par      = '0;
        up       = '0;
        smp      = '0;
        go       = 1'b0;
        wrap     = 1'b0;
        dn       = 1'b0;
        for (int i = 0; i < NVOICES; i++) begin
            busy[i]  = state_q[i] != IDLE;
            hit[i]   = busy[i] && key_q[i] == key_in;
            take[i]  = !busy[i] && !free_any;
            hit_any  = hit_any | hit[i];
            free_any = free_any | !busy[i];
        end
        drop_d = bus.note_on && !hit_any && !free_any;
        for (int i = 0; i < NVOICES; i++) begin
            state_d[i] = state_q[i];
            key_d[i]   = key_q[i];
            hp_d[i]    = hp_q[i];
            peak_d[i]  = peak_q[i];
            level_d[i] = level_q[i];
            sus        = bus.sustain < peak_q[i] ? bus.sustain : peak_q[i];
            par        = state_q[i] == ATTACK ? bus.attack : state_q[i] == DECAY ? bus.decay : bus.rel;
            go         = tick && step_q[i] >= par;
            up         = {1'b0, level_q[i]} + (AW+1)'(1);
            dn         = {1'b0, level_q[i]} <= {1'b0, sus} + (AW+1)'(1);
            wrap       = cnt_q[i] == hp_q[i] - 16'd1;
            cnt_d[i]   = busy[i] ? (wrap ? '0 : cnt_q[i] + 16'd1) : cnt_q[i];
            pol_d[i]   = pol_q[i] ^ (busy[i] && wrap);
            step_d[i]  = tick ? (go ? '0 : step_q[i] + AW'(1)) : step_q[i];
            if (go && state_q[i] == ATTACK) begin
                level_d[i] = up >= {1'b0, peak_q[i]} ? peak_q[i] : up[AW-1:0];
                state_d[i] = up >= {1'b0, peak_q[i]} ? DECAY : ATTACK;
            end else if (go && state_q[i] == DECAY) begin
                level_d[i] = dn ? sus : level_q[i] - AW'(1);
                state_d[i] = dn ? SUSTAIN : DECAY;
            end else if (go && state_q[i] == RELEASE) begin
                level_d[i] = level_q[i] == '0 ? '0 : level_q[i] - AW'(1);
                state_d[i] = level_q[i] <= AW'(1) ? IDLE : RELEASE;
            end
            if (state_d[i] != state_q[i]) step_d[i] = '0;
            // Events override the envelope step taken in the same cycle.
            if (bus.note_on && (hit[i] || (!hit_any && take[i]))) begin
                state_d[i] = ATTACK;
                step_d[i]  = '0;
                key_d[i]   = key_in;
                hp_d[i]    = bus.half_period;
                peak_d[i]  = bus.amplitude;
                level_d[i] = hit[i] ? level_q[i] : '0;
                cnt_d[i]   = hit[i] ? cnt_d[i] : '0;
                pol_d[i]   = hit[i] && pol_d[i];
            end else if (bus.note_off && !bus.note_on && hit[i] && state_q[i] != RELEASE) begin
                state_d[i] = RELEASE;
                step_d[i]  = '0;
                level_d[i] = level_q[i];
            end
            smp    = (busy[i] && hp_q[i] != '0) ?
                     (pol_q[i] ? -$signed({1'b0, level_q[i]}) : $signed({1'b0, level_q[i]})) : '0;
            wave_d = wave_d + {{(OW-AW-1){smp[AW]}}, smp};
        end
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            pre_q   <= '0;
            wave_q  <= '0;
            drop_q  <= 1'b0;
            state_q <= '{default: IDLE};
            key_q   <= '{default: '0};
            hp_q    <= '{default: '0};
            cnt_q   <= '{default: '0};
            peak_q  <= '{default: '0};
            level_q <= '{default: '0};
            step_q  <= '{default: '0};
            pol_q   <= '{default: 1'b0};
        end else begin
            pre_q   <= pre_d;
            wave_q  <= wave_d;
            drop_q  <= drop_d;
            state_q <= state_d;
            key_q   <= key_d;
            hp_q    <= hp_d;
            cnt_q   <= cnt_d;
            peak_q  <= peak_d;
            level_q <= level_d;
            step_q  <= step_d;
            pol_q   <= pol_d;
        end
    end
    assign bus.wave_out   = wave_q;
    assign bus.voice_busy = busy;
    assign bus.drop       = drop_q;
endmodule

// File: doc/poly_alu_controller.md
# poly_alu_controller

Polyphonic successor to the single-voice synth ALU controller. It accepts note-on/note-off events and allocates each note to one of `NVOICES` voice slots. Each voice runs its own square-wave oscillator and linear ADSR envelope. The signed voice samples are summed into one registered two's-complement output for the audio output stage.

## Interface
- `NVOICES`, default 4: number of voice slots; must be 2..8.
- `AW`, default 6: width of the amplitude, envelope level and ADSR parameters.
- `TICK_DIV`, default 50000: clk cycles per envelope tick; must be ≥ 1.
- `OW`, default `AW+1+$clog2(NVOICES)`: width of `wave_out`.

Ports:
- `clk`, in, 1: clock; all logic is on the rising edge.
- `reset`, in, 1: synchronous, active-low.
- `note_on`, in, 1: one-cycle pulse that starts the note given by `note`/`octave`.
- `note_off`, in, 1: one-cycle pulse that releases the note given by `note`/`octave`.
- `note`, in, 4: note index; used as part of the voice key.
- `octave`, in, 3: octave; the voice key is `{octave, note}`.
- `half_period`, in, 16: oscillator half-period in clk cycles, supplied by the note-to-frequency lookup. Sampled only on `note_on`.
- `amplitude`, in, AW: peak level. Sampled per voice on `note_on`.
- `attack`, `decay`, `sustain`, `rel`, in, AW each: ADSR parameters. Read live, not latched.
- `wave_out`, out, OW: signed sum of all voice samples. Registered.
- `voice_busy`, out, NVOICES: bit i is 1 while voice i is not IDLE.
- `drop`, out, 1: one-cycle pulse when a `note_on` finds no voice available.

## Operation
- **Per-voice state:** `key`, `hp`, `peak`, `level` (AW bits), oscillator counter, polarity bit, envelope FSM.
- **Envelope FSM states:** IDLE, ATTACK, DECAY, SUSTAIN, RELEASE.
- **Allocation on `note_on`, in priority order:**
  - A non-IDLE voice whose `key` matches is retriggered. It goes to ATTACK, keeps its current `level`, and reloads `hp` and `peak`.
  - Otherwise the lowest-index IDLE voice is taken. It loads `key`, `hp` and `peak`, sets `level`=0, clears the counter and sets polarity to 0. State goes to ATTACK.
  - Otherwise `drop` pulses and no voice changes.
- **`note_off`:** every voice with a matching key in ATTACK, DECAY or SUSTAIN goes to RELEASE. A non-matching `note_off` is ignored.
- **Simultaneous `note_on` and `note_off`:** `note_off` is ignored.
- **Envelope tick:** a free-running prescaler pulses `tick` once every `TICK_DIV` cycles. Each voice has a step counter and steps its envelope on every (P+1)-th tick, where P is the parameter for its current state (`attack`, `decay` or `rel`). The step counter clears on every state change.
- **Sustain threshold:** `sus_eff` = min(`sustain`, `peak`).
- **ATTACK step:** `level`+1. At `level`≥`peak`, clamp `level` to `peak` and go to DECAY.
- **DECAY step:** `level`−1. At `level`≤`sus_eff`, go to SUSTAIN with `level`=`sus_eff`.
- **SUSTAIN:** holds `level` until `note_off`.
- **RELEASE step:** `level`−1. At 0, go to IDLE. A voice in RELEASE may be retriggered by a matching key, but is never taken for a new key while it is not IDLE.
- **Oscillator:** the counter increments each cycle while the voice is not IDLE. At `hp`−1 the counter clears and polarity toggles. If `hp`=0, the voice sample is 0.
- **Voice sample:** polarity 0 gives +`level`; polarity 1 gives −`level` (AW+1-bit signed). IDLE voices contribute 0.
- **Mix:** `wave_out` is the sign-extended sum of all samples. It cannot overflow at the given `OW`.

## Timing
- **Reset (`reset`=0 at an edge):**
  - All voices go to IDLE with `level`, counters, polarity and `key` cleared.
  - The prescaler clears.
  - `wave_out`=0, `voice_busy`=0, `drop`=0.
  - This applies mid-note as well; any pending event in the same cycle is discarded.
- **`note_on` sampled at edge N:**
  - The voice is in ATTACK and its `voice_busy` bit is 1 after edge N.
  - `drop`, when generated, is high for the cycle after edge N.
  - `level` first becomes 1 on the first qualifying tick after edge N.
- **Output latency:** `wave_out` reflects voice state one cycle later (registered mix).
- **`note_off` at edge N:** the voice is in RELEASE after edge N.
- **Parameter changes:** take effect on the next step evaluation.

## Test plan
1. **Single note.** With `TICK_DIV`=1, `attack`=`decay`=`rel`=0, `amplitude`=8, `sustain`=4, `half_period`=3: send `note_on` key {4,9}. Required: `level` ramps 1..8 then 7..4 (one step per cycle); `wave_out` alternates ±`level` every 3 cycles; `voice_busy`=0001.
2. **Polyphony.** Send 4 distinct `note_on` events with `amplitude`=8 and `sustain`=8; at SUSTAIN `wave_out` equals the signed sum of the four ±8 samples. A 5th distinct key produces a `drop` pulse and leaves `voice_busy`=1111 unchanged.
3. **Release and reuse.** `note_off` key of voice 1 takes `level` to 0 in 8 steps, then `voice_busy`=1101. A new key then lands in voice 1.
4. **Retrigger.** `note_on` with the same key while voice 0 is in RELEASE at `level` 3: no new voice is used, and voice 0 returns to ATTACK from 3.
5. **Event and reset edge cases.**
   - `note_on` and `note_off` in the same cycle: the note starts.
   - `note_off` for an unused key: no change.
   - `reset`=0 during SUSTAIN: the next cycle shows `wave_out`=0 and `voice_busy`=0.
6. **Silent voice and clamping.** `half_period`=0 leaves `wave_out`=0 while `voice_busy`=1. `sustain`>`amplitude` makes the voice sustain at `amplitude`.
